dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port (ram: wen, byte_en, addr, data) between two requesters.
- Port 0 is the CPU load/store unit; port 1 is a debug/preload master that writes and reads memory while the CPU runs.
- Round-robin arbitration, one transaction in flight, fixed read latency. Sits between the cpu/loader and the dmem instance in the top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable width.
- RD_LAT, 1, number of cycles from address presentation to valid mem_rdata. Legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request valid. Held with its fields until gnt.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  byte address.
- wdata0 / wdata1  in  DATA_W  write data.
- be0 / be1  in  BE_W  write byte enables.
- gnt0 / gnt1  out  1  request accepted this cycle (combinational).
- rvalid0 / rvalid1  out  1  read data valid, one-cycle pulse.
- rdata0 / rdata1  out  DATA_W  read data. Meaningful only while the matching rvalid is high.
- mem_wen  out  1  memory write enable.
- mem_byte_en  out  BE_W  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- States: IDLE, RD_WAIT. Registers: state, owner (1 bit), last (1 bit), cnt (2 bits).
- Reset values:
  - state = IDLE, last = 1 (port 0 wins the first tie), cnt = 0.
  - All gnt/rvalid = 0, mem_wen = 0, mem_byte_en = 0.
  - mem_addr = 0, mem_wdata = 0, rdata = 0.
- IDLE arbitration:
  - Only req0: grant port 0. Only req1: grant port 1.
  - Both: grant the port != last.
  - Winner's gnt goes high combinationally in the same cycle; last <= winner at the clock edge.
- In the grant cycle:
  - mem_addr = winner addr. mem_wdata = winner wdata.
  - mem_wen = winner we.
  - mem_byte_en = winner be on a write; all ones on a read.
- Write grant:
  - Completes in the grant cycle; no rvalid.
  - State stays IDLE, so a new grant is possible in the very next cycle.
  - Back-to-back writes therefore sustain 1 per cycle.
- Read grant:
  - owner <= winner, cnt <= RD_LAT-1, state <= RD_WAIT.
  - mem_addr is held at the granted address for the whole wait.
- RD_WAIT:
  - No gnt, mem_wen = 0. cnt decrements each cycle.
  - In the cycle where cnt == 0: rvalid[owner] = 1 and rdata[owner] = mem_rdata (combinational pass-through). The other port's rvalid stays 0.
  - In that same cycle the arbiter returns to IDLE behaviour, so a new grant may coexist with the rvalid (the next address is driven that cycle).
- Read latency: for a read granted in cycle T, rvalid is high in cycle T+RD_LAT.
- Idle outputs:
  - When no grant and not in the final RD_WAIT cycle: mem_wen = 0 and mem_byte_en = 0.
  - mem_addr holds its last value.
- Lost request: a req dropped before gnt is silently lost. Not an error, no state change.
- Fairness: with both ports requesting continuously, grants strictly alternate. Maximum wait is one transaction.
- Reset asserted mid-read: the outstanding read is discarded, rvalid never fires, and all registers return to reset values immediately (asynchronously).
- Simultaneous events:
  - A read granted to port 0 in the same cycle as port 1's rvalid is legal.
  - Each port sees only its own rvalid.
- No address decoding, alignment check, or byte-lane shifting; the memory handles these.

Test Plan:
- Reset, then req0 write addr=0x10 wdata=0xDEADBEEF be=0xF -> gnt0=1 and mem_wen=1 the same cycle. A later port-1 read of 0x10 returns 0xDEADBEEF on rvalid1 exactly RD_LAT cycles after gnt1.
- req0 and req1 both held as reads from cycle 0, RD_LAT=1:
  - gnt0 in cycle 0; rvalid0 and gnt1 in cycle 1; rvalid1 in cycle 2.
  - Grant order 0,1,0,1 with both held continuously.
- Port 1 streams 4 writes (addr 0x0..0xC) while port 0 requests a read -> grants interleave 1,0,1,... The read on port 0 waits at most one write.
- be1=0x3 write of 0x12345678 to 0x20 over prior 0xFFFFFFFF -> mem_byte_en=0x3 in the grant cycle. Readback is 0xFFFF5678.
- Run with RD_LAT=3: read granted at T -> mem_addr stable during T..T+3, no gnt during T+1..T+2, rvalid at T+3.
- Assert rst_n=0 one cycle after a read grant -> no rvalid is ever produced. After release, the first tie goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data-memory port between CPU LSU and debug master
// Writes finish in their grant cycle; reads hold the port for RD_LAT cycles with one read outstanding.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [BE_W-1:0]   be0,
  input  logic [BE_W-1:0]   be1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wen,
  output logic [BE_W-1:0]   mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [1:0] LAT_CNT = 2'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic              last, last_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              rd_done;
  logic              arb_en;
  logic              grant;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;

  // The final wait cycle behaves like IDLE so a new grant can overlap the rvalid.
  assign rd_done = (state == RD_WAIT) && (cnt == 2'd0);
  assign arb_en  = rst_n && ((state == IDLE) || rd_done);

  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    if (arb_en) begin
      if (req0 && req1) begin
        grant = 1'b1;
        win   = ~last;
      end else if (req0) begin
        grant = 1'b1;
        win   = 1'b0;
      end else if (req1) begin
        grant = 1'b1;
        win   = 1'b1;
      end
    end
  end

  assign win_we    = win ? we1    : we0;
  assign win_addr  = win ? addr1  : addr0;
  assign win_wdata = win ? wdata1 : wdata0;
  assign win_be    = win ? be1    : be0;

  assign gnt0 = grant && !win;
  assign gnt1 = grant && win;

  assign mem_wen     = grant && win_we;
  assign mem_byte_en = grant ? (win_we ? win_be : {BE_W{1'b1}}) : {BE_W{1'b0}};
  assign mem_addr    = grant ? win_addr  : addr_q;
  assign mem_wdata   = grant ? win_wdata : wdata_q;

  assign rvalid0 = rd_done && !owner;
  assign rvalid1 = rd_done && owner;
  assign rdata0  = rvalid0 ? mem_rdata : {DATA_W{1'b0}};
  assign rdata1  = rvalid1 ? mem_rdata : {DATA_W{1'b0}};

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    if ((state == RD_WAIT) && (cnt != 2'd0)) begin
      cnt_nxt = cnt - 2'd1;
    end
    if (rd_done) begin
      state_nxt = IDLE;
    end
    if (grant) begin
      last_nxt = win;
      if (!win_we) begin
        state_nxt = RD_WAIT;
        owner_nxt = win;
        cnt_nxt   = LAT_CNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      cnt     <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
      end
    end
  end

endmodule
